adat_rx_tdm_tx: RTL and testbench
=================================

Name: adat_rx_tdm_tx

Overview:
- Downstream consumer of the ADAT receiver. Takes each decoded 8-channel, 24-bit sample frame (`o_channels` / `o_valid` / `o_locked`) and serializes it onto a free-running TDM8 link (BCLK, FSYNC, SDATA) for a DAC, DSP or codec.
- Holds a one-deep pending buffer between the ADAT frame rate and the local TDM frame rate.
- Repeats the previous frame on underrun, flags overrun, and mutes while the receiver is unlocked.

Parameters:
- BCLK_DIV, 4, i_clk cycles per BCLK half-period (>=1). Bit period is 2*BCLK_DIV cycles.
- DATA_BITS, 24, audio bits per channel, sent MSB-first.
- SLOT_BITS, 32, BCLK periods per TDM slot (>= DATA_BITS). Frame length is 8*SLOT_BITS bits.

Ports:
- i_clk  in  1  system clock; the only clock.
- i_rst  in  1  synchronous, active-high reset.
- i_channels  in  8 x DATA_BITS  channel words, index 0..7, from the receiver.
- i_valid  in  1  one-cycle strobe; i_channels is valid in that cycle.
- i_locked  in  1  receiver lock status.
- o_bclk  out  1  TDM bit clock.
- o_fsync  out  1  frame sync; high for exactly bit 0 of slot 0.
- o_sdata  out  1  serial data.
- o_frame_start  out  1  one-cycle pulse at each TDM frame boundary.
- o_underrun  out  1  one-cycle pulse: frame started with no new data while locked.
- o_overrun  out  1  one-cycle pulse: pending data overwritten before it was consumed.

Behaviour:
- Reset (i_rst=1 at a clock edge):
  - All outputs go to 0.
  - div_cnt=0, bit_cnt=0.
  - Active buffer is all zeros; pending_valid=0.
- Timing generator:
  - div_cnt counts 0..2*BCLK_DIV-1 and wraps.
  - o_bclk = (div_cnt >= BCLK_DIV), registered: low half first, then high half.
  - A bit boundary is the cycle with div_cnt==0. bit_cnt increments modulo 8*SLOT_BITS at each boundary.
  - The first cycle after reset release is a boundary with bit_cnt=0, i.e. a frame start.
- Output timing:
  - o_sdata and o_fsync change only on bit boundaries, coincident with the BCLK falling edge. They are stable across the rising edge, so the receiver samples on rising edges.
  - Mode is DSP/0-bit-delay: o_fsync=1 for the whole bit period where bit_cnt==0, and the MSB of slot 0 is driven in that same period.
- Slot mapping:
  - slot = bit_cnt / SLOT_BITS; b = bit_cnt % SLOT_BITS.
  - o_sdata = active[slot][DATA_BITS-1-b] when b < DATA_BITS, else 0 (zero padding).
- Frame-start transfer (boundary with bit_cnt==0). o_frame_start pulses in that cycle, then:
  - i_locked=0: active <= zeros, pending_valid <= 0, no underrun.
  - i_locked=1, pending_valid=1: active <= pending, pending_valid <= 0.
  - i_locked=1, pending_valid=0: active unchanged (previous frame repeats), o_underrun pulses.
  - The bits driven in the frame-start cycle already come from the newly selected active content.
- Capture (any cycle with i_valid=1 and i_locked=1):
  - pending <= i_channels; pending_valid <= 1.
  - If pending_valid was 1 and is not being consumed in the same cycle, o_overrun pulses and the old data is lost.
- Simultaneous frame-start transfer and i_valid:
  - The transfer takes the old pending content.
  - The new data lands in pending with pending_valid=1; no overrun is flagged.
- i_valid while i_locked=0 is ignored.
- i_locked falling mid-frame:
  - The current frame finishes unchanged.
  - pending is discarded at the next frame start, and zeros are transmitted from then on.
- Latency: data captured at cycle t is first driven at the next frame start after t. Worst case is 8*SLOT_BITS*2*BCLK_DIV+1 cycles.
- Timing never stops or resyncs to i_valid. Rate mismatch is absorbed solely by the repeat/overrun rules above.
- Reset mid-frame aborts immediately; the next frame begins at bit_cnt=0 on the first cycle after release.

Test Plan:
- Reset release, i_locked=0, no i_valid -> o_bclk toggles with period 8 cycles; o_fsync high for 8 cycles every 2048 cycles; o_sdata constant 0.
- i_locked=1, one i_valid with ch0=123456 … ch7=ABCDEF mid-frame -> from the next frame start, shifting SDATA on BCLK rising edges yields 123456 in slot 0 bits 0-23, zeros in bits 24-31, and ABCDEF in slot 7.
- No further i_valid after the frame above -> each following frame repeats identical data; o_underrun pulses once per frame start.
- Two i_valid strobes (AA0000…, then BB0000…) within one TDM frame -> exactly one o_overrun pulse; the next frame carries BB0000… in slot 0.
- i_valid in the same cycle as o_frame_start -> that frame carries the previous pending data; the following frame carries the new data; no o_overrun.
- i_locked dropped to 0 mid-frame, then i_rst pulsed during a later frame -> the current frame completes intact, then zeros are sent; after reset, o_fsync asserts on the first post-release cycle and all flags stay 0.

Source files
------------

// File: rtl/adat_rx_tdm_tx.sv
`default_nettype none
// ============================================================================
// Module   : adat_rx_tdm_tx
// Function : Re-serialises decoded ADAT sample frames (8 ch x DATA_BITS) onto
//            a free-running TDM8 link (BCLK / FSYNC / SDATA, DSP mode,
//            0-bit delay). A one-deep pending buffer bridges the ADAT and
//            TDM frame rates: underrun repeats the previous frame, overrun
//            drops the older pending frame, loss of lock mutes.
// Revision : 1.0 - initial release
// ============================================================================
module adat_rx_tdm_tx #(
    parameter int BCLK_DIV  = 4,
    parameter int DATA_BITS = 24,
    parameter int SLOT_BITS = 32
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [7:0][DATA_BITS-1:0] i_channels,
    input  logic                      i_valid,
    input  logic                      i_locked,
    output logic                      o_bclk,
    output logic                      o_fsync,
    output logic                      o_sdata,
    output logic                      o_frame_start,
    output logic                      o_underrun,
    output logic                      o_overrun
);

    localparam int c_DIV_W = $clog2(2 * BCLK_DIV);
    localparam int c_BIT_W = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(2 * BCLK_DIV - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_HALF = c_DIV_W'(BCLK_DIV);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(SLOT_BITS - 1);

    // Timing state: the frame bit counter is kept as (slot, bit-in-slot).
    logic [c_DIV_W-1:0]        r_div;
    logic [2:0]                r_slot;
    logic [c_BIT_W-1:0]        r_bit;

    // Sample buffers.
    logic [7:0][DATA_BITS-1:0] r_active;
    logic [7:0][DATA_BITS-1:0] r_pending;
    logic                      r_pend_valid;

    logic                      w_boundary;
    logic                      w_frame_start;
    logic                      w_capture;
    logic [7:0][DATA_BITS-1:0] w_active_next;
    logic [7:0][DATA_BITS-1:0] w_sel;
    logic [DATA_BITS-1:0]      w_word;
    logic [DATA_BITS-1:0]      w_shift;
    logic                      w_sdata;

    assign w_boundary    = (r_div == '0);
    assign w_frame_start = w_boundary && (r_slot == 3'd0) && (r_bit == '0);
    assign w_capture     = i_valid && i_locked;

    // Content the active buffer takes at a frame start: mute, fresh, or repeat.
    always_comb begin
        w_active_next = r_active;
        if (!i_locked) begin
            w_active_next = '0;
        end else if (r_pend_valid) begin
            w_active_next = r_pending;
        end
    end

    // Bit to drive: in a frame-start cycle it already comes from the new content.
    // Shifting left by the bit index leaves zero once past DATA_BITS (padding).
    always_comb begin
        w_sel   = w_frame_start ? w_active_next : r_active;
        w_word  = w_sel[r_slot];
        w_shift = w_word << r_bit;
        w_sdata = w_shift[DATA_BITS-1];
    end

    // Free-running BCLK divider and frame bit position.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div  <= '0;
            r_slot <= 3'd0;
            r_bit  <= '0;
            o_bclk <= 1'b0;
        end else begin
            r_div  <= (r_div == c_DIV_LAST) ? '0 : r_div + 1'b1;
            o_bclk <= (r_div >= c_DIV_HALF);
            if (w_boundary) begin
                if (r_bit == c_BIT_LAST) begin
                    r_bit  <= '0;
                    r_slot <= r_slot + 3'd1;
                end else begin
                    r_bit  <= r_bit + 1'b1;
                end
            end
        end
    end

    // Serial outputs and frame-start transfer, updated on BCLK falling edges.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_active      <= '0;
            o_fsync       <= 1'b0;
            o_sdata       <= 1'b0;
            o_frame_start <= 1'b0;
            o_underrun    <= 1'b0;
        end else begin
            o_frame_start <= w_frame_start;
            o_underrun    <= w_frame_start && i_locked && !r_pend_valid;
            if (w_frame_start) begin
                r_active <= w_active_next;
            end
            if (w_boundary) begin
                o_fsync <= w_frame_start;
                o_sdata <= w_sdata;
            end
        end
    end

    // Pending buffer: capture from the receiver, release at frame start.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pending    <= '0;
            r_pend_valid <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            o_overrun <= w_capture && r_pend_valid && !w_frame_start;
            if (w_capture) begin
                r_pending    <= i_channels;
                r_pend_valid <= 1'b1;
            end else if (w_frame_start) begin
                r_pend_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adat_rx_tdm_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_adat_rx_tdm_tx
// Function : Self-checking bench for adat_rx_tdm_tx: frame-level table of
//            scenarios, a cycle-accurate reference of the TDM link, and a
//            BCLK-rising-edge deserialiser for slot content checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adat_rx_tdm_tx;

    localparam int c_DIV   = 4;
    localparam int c_SLOT  = 32;
    localparam int c_DATA  = 24;
    localparam int c_FBITS = 8 * c_SLOT;
    localparam int c_FCYC  = c_FBITS * 2 * c_DIV;

    logic             clk;
    logic             t_rst;
    logic [7:0][23:0] t_data;
    logic             t_valid;
    logic             t_locked;
    logic             o_bclk, o_fsync, o_sdata, o_frame_start, o_underrun, o_overrun;

    adat_rx_tdm_tx #(.BCLK_DIV(c_DIV), .DATA_BITS(c_DATA), .SLOT_BITS(c_SLOT)) dut (
        .i_clk         (clk),
        .i_rst         (t_rst),
        .i_channels    (t_data),
        .i_valid       (t_valid),
        .i_locked      (t_locked),
        .o_bclk        (o_bclk),
        .o_fsync       (o_fsync),
        .o_sdata       (o_sdata),
        .o_frame_start (o_frame_start),
        .o_underrun    (o_underrun),
        .o_overrun     (o_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;

    // Reference model state
    int               m_n;
    logic [7:0][23:0] m_act, m_pend;
    bit               m_pv;
    logic [5:0]       m_exp;   // {bclk, fsync, sdata, frame_start, underrun, overrun}

    // Deserialiser and per-frame counters
    bit               rx_bits [c_FBITS];
    int               rx_idx;
    logic             prev_bclk;
    int               cnt_fs, cnt_un, cnt_ov;

    typedef struct {
        bit          locked;
        int          nvalid;
        int          off1;
        logic [23:0] w1;
        int          off2;
        logic [23:0] w2;
        int          unlock_at;
        int          exp_un;
        int          exp_ov;
        logic [23:0] exp_s0;
        logic [23:0] exp_s7;
    } rec_t;

    rec_t tbl [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] rx_word(input int slot);
        logic [23:0] w = '0;
        for (int i = 0; i < 24; i++) w = {w[22:0], rx_bits[slot*c_SLOT + i]};
        return w;
    endfunction

    // One clock: update model from the inputs seen at the edge, then compare.
    task automatic step();
        int dv, bp, sl, b;
        bit fst;
        @(posedge clk);
        if (t_rst) begin
            m_n = 0; m_act = '0; m_pend = '0; m_pv = 0; m_exp = '0;
        end else begin
            dv  = m_n % (2 * c_DIV);
            bp  = (m_n / (2 * c_DIV)) % c_FBITS;
            fst = (dv == 0) && (bp == 0);
            m_exp[5] = (dv >= c_DIV);
            m_exp[2] = fst;
            m_exp[1] = 1'b0;
            m_exp[0] = 1'b0;
            if (fst) begin
                if (!t_locked)  m_act = '0;
                else if (m_pv)  m_act = m_pend;
                else            m_exp[1] = 1'b1;
            end
            if (t_valid && t_locked) begin
                m_exp[0] = m_pv && !fst;
                m_pend   = t_data;
                m_pv     = 1;
            end else if (fst) begin
                m_pv = 0;
            end
            if (dv == 0) begin
                sl = bp / c_SLOT;
                b  = bp % c_SLOT;
                m_exp[3] = (b < c_DATA) ? m_act[sl][c_DATA-1-b] : 1'b0;
                m_exp[4] = (bp == 0);
            end
            m_n++;
        end
        #1;
        check($sformatf("cycle%0d{bclk,fsync,sdata,fstart,under,over}", m_n),
              {26'd0, o_bclk, o_fsync, o_sdata, o_frame_start, o_underrun, o_overrun},
              {26'd0, m_exp});
        cnt_fs += int'(o_frame_start);
        cnt_un += int'(o_underrun);
        cnt_ov += int'(o_overrun);
        if (o_bclk && !prev_bclk) begin
            if (o_fsync) rx_idx = 0;
            if (rx_idx >= 0 && rx_idx < c_FBITS) rx_bits[rx_idx] = o_sdata;
            rx_idx++;
        end
        prev_bclk = o_bclk;
    endtask

    task automatic set_data(input logic [23:0] w);
        t_data[0] = w;
        for (int k = 1; k < 7; k++) t_data[k] = 24'($urandom);
        t_data[7] = w ^ 24'hB9F9B9;
    endtask

    // Runs one TDM frame, starting on its frame-start clock.
    task automatic run_frame(input int id, input rec_t r);
        int pad_err = 0;
        cnt_fs = 0; cnt_un = 0; cnt_ov = 0; rx_idx = -1000;
        for (int c = 0; c < c_FCYC; c++) begin
            t_locked = (c < r.unlock_at) ? r.locked : 1'b0;
            t_valid  = 1'b0;
            if (r.nvalid >= 1 && c == r.off1) begin t_valid = 1'b1; set_data(r.w1); end
            if (r.nvalid >= 2 && c == r.off2) begin t_valid = 1'b1; set_data(r.w2); end
            step();
            if (c == 0) check($sformatf("frame%0d start alignment", id), {31'd0, o_frame_start}, 32'd1);
            t_valid = 1'b0;
        end
        for (int s = 0; s < 8; s++)
            for (int i = c_DATA; i < c_SLOT; i++) pad_err += int'(rx_bits[s*c_SLOT + i]);
        check($sformatf("frame%0d bits received", id), rx_idx,       c_FBITS);
        check($sformatf("frame%0d frame_start count", id), cnt_fs,   1);
        check($sformatf("frame%0d underrun count", id), cnt_un,      r.exp_un);
        check($sformatf("frame%0d overrun count", id), cnt_ov,       r.exp_ov);
        check($sformatf("frame%0d slot0 word", id), {8'd0, rx_word(0)}, {8'd0, r.exp_s0});
        check($sformatf("frame%0d slot7 word", id), {8'd0, rx_word(7)}, {8'd0, r.exp_s7});
        check($sformatf("frame%0d padding bits set", id), pad_err,   0);
    endtask

    initial begin
        //           lk nv off1  w1          off2 w2          unlock un ov s0          s7
        tbl[0] = '{0, 0, 0,    24'h0,      0,   24'h0,      c_FCYC, 0, 0, 24'h000000, 24'h000000};
        tbl[1] = '{1, 1, 700,  24'h123456, 0,   24'h0,      c_FCYC, 1, 0, 24'h000000, 24'h000000};
        tbl[2] = '{1, 0, 0,    24'h0,      0,   24'h0,      c_FCYC, 0, 0, 24'h123456, 24'hABCDEF};
        tbl[3] = '{1, 0, 0,    24'h0,      0,   24'h0,      c_FCYC, 1, 0, 24'h123456, 24'hABCDEF};
        tbl[4] = '{1, 2, 100,  24'hAA0000, 900, 24'hBB0000, c_FCYC, 1, 1, 24'h123456, 24'hABCDEF};
        tbl[5] = '{1, 1, 0,    24'hCC0000, 0,   24'h0,      c_FCYC, 0, 0, 24'hBB0000, 24'h02F9B9};
        tbl[6] = '{1, 0, 0,    24'h0,      0,   24'h0,      c_FCYC, 0, 0, 24'hCC0000, 24'h75F9B9};
        tbl[7] = '{1, 1, 1500, 24'h5A5A5A, 0,   24'h0,      c_FCYC, 1, 0, 24'hCC0000, 24'h75F9B9};
        tbl[8] = '{1, 1, 300,  24'h777777, 0,   24'h0,      1000,   0, 0, 24'h5A5A5A, 24'hE3A3E3};
        tbl[9] = '{0, 0, 0,    24'h0,      0,   24'h0,      c_FCYC, 0, 0, 24'h000000, 24'h000000};

        t_rst = 1'b1; t_valid = 1'b0; t_locked = 1'b0; t_data = '0;
        prev_bclk = 1'b0; rx_idx = -1000; m_n = 0; m_pv = 0; m_act = '0; m_pend = '0; m_exp = '0;
        for (int i = 0; i < 3; i++) step();
        t_rst = 1'b0;

        for (int i = 0; i < 10; i++) run_frame(i, tbl[i]);

        // Reset in the middle of a frame restarts timing on the next cycle.
        for (int i = 0; i < 500; i++) step();
        t_rst = 1'b1;
        step();
        step();
        t_rst = 1'b0;
        run_frame(10, tbl[9]);

        // Randomised traffic: strobes at arbitrary times, occasional lock changes.
        t_locked = 1'b1;
        for (int c = 0; c < 6 * c_FCYC; c++) begin
            t_valid = ($urandom_range(0, 799) == 0);
            if (t_valid) set_data(24'($urandom));
            if ($urandom_range(0, 2999) == 0) t_locked = ~t_locked;
            step();
            t_valid = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
